// File: rtl/mult_seq16.sv
// Sequential 16x16 unsigned shift-add multiplier: one add/shift per clock through a
// single carry-lookahead adder, with valid/ready handshakes on both sides.

module cla16 (
   input  logic [15:0] a_i,
   input  logic [15:0] b_i,
   input  logic        cin_i,
   output logic [15:0] sum_o,
   output logic        cout_o
);

   logic [15:0] g, p, c;
   logic [3:0]  grp_g, grp_p;
   logic [4:0]  grp_c;

   // Four 4-bit groups; group carries are resolved by lookahead, bit carries ripple inside a group.
   always_comb begin
      g = a_i & b_i;
      p = a_i ^ b_i;
      for (int k = 0; k < 4; k++) begin
         grp_g[k] = g[4*k+3] | (p[4*k+3] & g[4*k+2]) | (p[4*k+3] & p[4*k+2] & g[4*k+1]) |
                    (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
         grp_p[k] = &p[4*k +: 4];
      end
      grp_c[0] = cin_i;
      for (int k = 0; k < 4; k++) begin
         grp_c[k+1] = grp_g[k] | (grp_p[k] & grp_c[k]);
      end
      for (int i = 0; i < 16; i++) begin
         if (i % 4 == 0) c[i] = grp_c[i/4];
         else            c[i] = g[i-1] | (p[i-1] & c[i-1]);
      end
      sum_o  = p ^ c;
      cout_o = grp_c[4];
   end

endmodule

module mult_seq16 #(
   parameter int WIDTH = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               flush,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [2*WIDTH-1:0] product
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [31:0] acc_q, acc_d;
   logic [15:0] mcand_q, mcand_d;
   logic [31:0] product_q, product_d;

   logic [15:0] add_sum;
   logic        add_cout;
   logic [16:0] partial;
   logic [31:0] acc_shift;

   cla16 u_cla (
      .a_i    (acc_q[31:16]),
      .b_i    (mcand_q),
      .cin_i  (1'b0),
      .sum_o  (add_sum),
      .cout_o (add_cout)
   );

   // The adder carry becomes the new MSB after the shift, so no product bit is lost.
   assign partial   = acc_q[0] ? {add_cout, add_sum} : {1'b0, acc_q[31:16]};
   assign acc_shift = {partial, acc_q[15:1]};

   always_comb begin
      // NOTE: every next-state signal gets a default first so no path infers a latch.
      state_d   = state_q;
      cnt_d     = cnt_q;
      acc_d     = acc_q;
      mcand_d   = mcand_q;
      product_d = product_q;
      if (flush) begin
         state_d = IDLE;
         cnt_d   = 4'd0;
      end else begin
         unique case (state_q)
            IDLE: if (in_valid) begin
               mcand_d = a;
               acc_d   = {16'd0, b};
               cnt_d   = 4'd0;
               state_d = RUN;
            end
            RUN: begin
               acc_d = acc_shift;
               cnt_d = cnt_q + 4'd1;
               if (cnt_q == 4'd15) begin
                  product_d = acc_shift;
                  state_d   = DONE;
               end
            end
            DONE: if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

   // NOTE: state is updated with non-blocking assignments so all registers see the same pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         cnt_q     <= 4'd0;
         acc_q     <= 32'd0;
         mcand_q   <= 16'd0;
         product_q <= 32'd0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         acc_q     <= acc_d;
         mcand_q   <= mcand_d;
         product_q <= product_d;
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign product   = product_q;

endmodule
